// File: rtl/garage_input_cond.sv
// Purpose : synchronises and debounces the garage door button and limit switches, emitting
//           one activate pulse per accepted press and a sticky fault when both limits are set.
// Latency : DB_CYCLES+2 clk edges from a clean raw edge to the debounced level; activate follows
//           the button level combinationally from registers, and sw_fault is one edge later.
// Backpressure: none. All inputs are sampled every cycle and all outputs are plain levels or pulses.
//
// Ports:
//   clk, rst        : system clock; asynchronous active-high reset
//   btn_raw         : raw push-button (async, bouncy)
//   up_sw_raw       : raw fully-open limit (async, bouncy)
//   dn_sw_raw       : raw fully-closed limit (async, bouncy)
//   fault_clr       : synchronous clear request for sw_fault
//   activate        : one-cycle pulse per accepted press
//   up_max, dn_max  : debounced limit levels
//   sw_fault        : sticky "both limits asserted" flag

// One debounce channel: a two-flop synchroniser followed by a run-length debouncer.
// Ports: clk, rst, raw_i (async raw level), stable_o (debounced level, resets to RST_VAL).
module gic_debounce #(
   parameter int   DB_CYCLES = 16,
   parameter int   CNT_W     = 5,
   parameter logic RST_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Synchroniser resets to the channel's idle level so that release of reset
   // does not look like a transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // The counter holds the number of consecutive differing samples seen so far.
   // When it already holds DB_CYCLES-1, the current differing sample is the
   // DB_CYCLES-th one, so the level is accepted and the count restarts.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= RST_VAL;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

module garage_input_cond #(
   parameter int DB_CYCLES = 16,   // legal 2..31
   parameter int CNT_W     = 5     // 2**CNT_W must exceed DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic up_sw_raw,
   input  logic dn_sw_raw,
   input  logic fault_clr,
   output logic activate,
   output logic up_max,
   output logic dn_max,
   output logic sw_fault
);

   logic btn_stable;
   logic up_stable;
   logic dn_stable;
   logic btn_prev_q;
   logic sw_fault_q;
   logic sw_fault_d;

   gic_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b0)) u_btn (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw),
      .stable_o (btn_stable)
   );

   gic_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b0)) u_up (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (up_sw_raw),
      .stable_o (up_stable)
   );

   // Door is assumed closed out of reset, so the closed limit idles high.
   gic_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b1)) u_dn (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (dn_sw_raw),
      .stable_o (dn_stable)
   );

   // Set has priority over clear: a clear request is ignored while both limits are on.
   always_comb begin
      sw_fault_d = sw_fault_q;
      if (up_stable && dn_stable) begin
         sw_fault_d = 1'b1;
      end else if (fault_clr) begin
         sw_fault_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_q <= 1'b0;
         sw_fault_q <= 1'b0;
      end else begin
         btn_prev_q <= btn_stable;
         sw_fault_q <= sw_fault_d;
      end
   end

   // High only in the first cycle of a debounced press. A press that lands
   // while the fault is set is dropped, not remembered.
   assign activate = btn_stable & ~btn_prev_q & ~sw_fault_q;
   assign up_max   = up_stable;
   assign dn_max   = dn_stable;
   assign sw_fault = sw_fault_q;

endmodule

// File: tb/tb_garage_input_cond.sv
// Bench for garage_input_cond with DB_CYCLES=4: directed scenarios plus a randomized bouncy phase,
// all outputs scoreboarded every cycle against a queue-based reference model.
module tb_garage_input_cond;

   localparam int DB = 4;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic btn_raw   = 1'b0;
   logic up_sw_raw = 1'b0;
   logic dn_sw_raw = 1'b1;
   logic fault_clr = 1'b0;
   logic activate;
   logic up_max;
   logic dn_max;
   logic sw_fault;

   int n_chk   = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pulses  = 0;
   int act_cyc = -1;

   typedef struct packed {
      logic act;
      logic up;
      logic dn;
      logic flt;
   } exp_t;

   exp_t sb[$];

   // Reference model state, channel 0 = button, 1 = up limit, 2 = down limit.
   bit m_stab[3];
   bit m_hist[3][$];   // raw values still travelling through the synchroniser
   bit m_run[3][$];    // most recent synchronised samples since the last level change
   bit m_flt;

   always #5 clk = ~clk;

   garage_input_cond #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .up_sw_raw (up_sw_raw),
      .dn_sw_raw (dn_sw_raw),
      .fault_clr (fault_clr),
      .activate  (activate),
      .up_max    (up_max),
      .dn_max    (dn_max),
      .sw_fault  (sw_fault)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int ch = 0; ch < 3; ch++) begin
         bit rv;
         rv = (ch == 2);
         m_stab[ch] = rv;
         m_hist[ch].delete();
         m_hist[ch].push_back(rv);
         m_hist[ch].push_back(rv);
         m_run[ch].delete();
      end
      m_flt = 1'b0;
   endfunction

   // Model: a level is accepted once the last DB synchronised samples all differ
   // from it; a synchronised sample is the raw value from two edges earlier.
   always @(posedge clk) begin
      exp_t e;
      bit   raw[3];
      bit   old_btn;
      bit   old_both;
      bit   s;
      bit   all_diff;
      cyc++;
      if (rst) begin
         model_reset();
         e = '{act: 1'b0, up: 1'b0, dn: 1'b1, flt: 1'b0};
      end else begin
         raw[0]   = btn_raw;
         raw[1]   = up_sw_raw;
         raw[2]   = dn_sw_raw;
         old_btn  = m_stab[0];
         old_both = m_stab[1] && m_stab[2];
         for (int ch = 0; ch < 3; ch++) begin
            s = m_hist[ch][0];
            m_hist[ch].push_back(raw[ch]);
            void'(m_hist[ch].pop_front());
            m_run[ch].push_back(s);
            if (m_run[ch].size() > DB) void'(m_run[ch].pop_front());
            all_diff = (m_run[ch].size() == DB);
            for (int j = 0; j < m_run[ch].size(); j++)
               if (m_run[ch][j] == m_stab[ch]) all_diff = 1'b0;
            if (all_diff) begin
               m_stab[ch] = s;
               m_run[ch].delete();
            end
         end
         if (old_both) m_flt = 1'b1;
         else if (fault_clr) m_flt = 1'b0;
         e.act = m_stab[0] && !old_btn && !m_flt;
         e.up  = m_stab[1];
         e.dn  = m_stab[2];
         e.flt = m_flt;
      end
      sb.push_back(e);
   end

   // Monitor: compare every presented cycle against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("activate", activate, e.act);
         check("up_max", up_max, e.up);
         check("dn_max", dn_max, e.dn);
         check("sw_fault", sw_fault, e.flt);
      end
      if (activate === 1'b1) begin
         pulses++;
         act_cyc = cyc;
      end
   end

   // Assert reset just after a falling edge, check outputs before the next rising edge.
   task automatic do_reset(input int n);
      #1 rst = 1'b1;
      #1;
      check("rst_activate", activate, 0);
      check("rst_up_max", up_max, 0);
      check("rst_dn_max", dn_max, 1);
      check("rst_sw_fault", sw_fault, 0);
      btn_raw = 1'b0;
      repeat (n) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int p0;
      int chg;
      int w;
      bit tgt[3];
      int bnc[3];
      bit v[3];

      // Power-on reset state
      @(negedge clk);
      check("por_activate", activate, 0);
      check("por_up_max", up_max, 0);
      check("por_dn_max", dn_max, 1);
      check("por_sw_fault", sw_fault, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);

      // Clean press held 20 cycles: one pulse exactly 6 edges after the change
      p0 = pulses; btn_raw = 1'b1; chg = cyc;
      repeat (20) @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);
      check("press_pulse_count", pulses - p0, 1);
      check("press_pulse_edge", act_cyc - chg, 6);

      // Short 3-cycle glitch: no pulse
      p0 = pulses; btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_pulse_count", pulses - p0, 0);

      // Toggle every cycle for 10 cycles, then hold high
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         btn_raw = (i % 2 == 0);
         @(negedge clk);
      end
      btn_raw = 1'b1; chg = cyc;
      repeat (14) @(negedge clk);
      check("bounce_pulse_count", pulses - p0, 1);
      check("bounce_pulse_edge", act_cyc - chg, 6);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);

      // Simultaneous limit swap: both change on edge 6, never both high
      dn_sw_raw = 1'b0; up_sw_raw = 1'b1;
      repeat (5) @(negedge clk);
      check("swap_dn_edge5", dn_max, 1);
      check("swap_up_edge5", up_max, 0);
      @(negedge clk);
      check("swap_dn_edge6", dn_max, 0);
      check("swap_up_edge6", up_max, 1);
      check("swap_fault", sw_fault, 0);
      dn_sw_raw = 1'b1; up_sw_raw = 1'b0;
      repeat (8) @(negedge clk);
      check("swap_back_fault", sw_fault, 0);
      check("swap_back_dn", dn_max, 1);

      // Reset mid-count: no pulse after release
      p0 = pulses; btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      do_reset(3);
      repeat (15) @(negedge clk);
      check("rst_abort_pulse_count", pulses - p0, 0);

      // Fault scenario
      up_sw_raw = 1'b1;
      repeat (5) @(negedge clk);
      check("flt_up_edge5", up_max, 0);
      @(negedge clk);
      check("flt_up_edge6", up_max, 1);
      check("flt_fault_edge6", sw_fault, 0);
      @(negedge clk);
      check("flt_fault_edge7", sw_fault, 1);
      p0 = pulses; btn_raw = 1'b1;
      repeat (12) @(negedge clk);
      btn_raw = 1'b0;
      repeat (8) @(negedge clk);
      check("flt_suppressed_pulse", pulses - p0, 0);
      up_sw_raw = 1'b0;
      w = 0;
      while (up_max !== 1'b0 && w < 30) begin
         @(negedge clk);
         w++;
      end
      check("flt_up_release_wait", up_max, 0);
      @(negedge clk);
      check("flt_sticky", sw_fault, 1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("flt_cleared", sw_fault, 0);
      p0 = pulses; btn_raw = 1'b1; chg = cyc;
      repeat (12) @(negedge clk);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("post_clr_pulse_count", pulses - p0, 1);
      check("post_clr_pulse_edge", act_cyc - chg, 6);

      // Randomized bouncy traffic on all channels
      tgt[0] = btn_raw; tgt[1] = up_sw_raw; tgt[2] = dn_sw_raw;
      for (int ch = 0; ch < 3; ch++) bnc[ch] = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i == 1200 || i == 2400) begin
            do_reset(2);
            tgt[0] = 1'b0;
         end
         for (int ch = 0; ch < 3; ch++) begin
            if ($urandom_range(0, 59) == 0) begin
               tgt[ch] = ~tgt[ch];
               bnc[ch] = $urandom_range(0, 7);
            end
            if (bnc[ch] > 0) begin
               v[ch] = bit'($urandom_range(0, 1));
               bnc[ch]--;
            end else begin
               v[ch] = tgt[ch];
            end
         end
         btn_raw   = v[0];
         up_sw_raw = v[1];
         dn_sw_raw = v[2];
         fault_clr = ($urandom_range(0, 19) == 0);
      end
      fault_clr = 1'b0;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/garage_input_cond.md
GARAGE_INPUT_COND -- requirements
Module: garage_input_cond

Interface
REQ-001 Parameter: DB_CYCLES, default 16, number of consecutive differing synchronized samples required to accept a new input level (legal range 2..31).
REQ-002 Parameter: CNT_W, default 5, width of each debounce counter; 2^CNT_W SHALL exceed DB_CYCLES.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-006 up_sw_raw  input  1  raw fully-open limit switch, active-high, asynchronous, may bounce.
REQ-007 dn_sw_raw  input  1  raw fully-closed limit switch, active-high, asynchronous, may bounce.
REQ-008 fault_clr  input  1  synchronous request to clear sw_fault.
REQ-009 activate  output  1  one-cycle pulse per accepted button press; drives the door controller's activate input.
REQ-010 up_max  output  1  debounced fully-open limit; drives the door controller's up_max input.
REQ-011 dn_max  output  1  debounced fully-closed limit; drives the door controller's dn_max input.
REQ-012 sw_fault  output  1  sticky flag: both debounced limits asserted together.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a stable level and a CNT_W-bit counter; a cycle with synchronized value equal to stable SHALL clear the counter to 0.
REQ-015 A cycle with synchronized value different from stable SHALL increment the counter; on the DB_CYCLES-th consecutive differing cycle stable SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-016 Total latency from a clean raw transition (set up before edge 1) to the debounced level change SHALL be exactly DB_CYCLES+2 rising edges.
REQ-017 Any raw pulse or bounce run shorter than DB_CYCLES synchronized cycles SHALL leave the stable level unchanged.
REQ-018 up_max and dn_max SHALL be the registered stable levels of their channels, with no further gating.
REQ-019 activate SHALL be 1 for exactly one cycle, the cycle in which the button stable level first becomes 1; it SHALL be 0 on a 1->0 transition and while the button is held.
REQ-020 activate SHALL be suppressed (held 0, event discarded, not deferred) when sw_fault is 1 in the cycle the button stable level rises.
REQ-021 sw_fault SHALL set on the rising edge following any cycle in which up_max and dn_max are both 1.
REQ-022 sw_fault SHALL clear on the rising edge following a cycle with fault_clr=1 and not both limits at 1; if set condition and fault_clr coincide, set SHALL win.
REQ-023 The three channels SHALL be independent; simultaneous transitions on several inputs SHALL each resolve per REQ-015 without interaction.

Reset
REQ-024 While rst=1, immediately and without a clock: all synchronizer flops 0, all counters 0, activate=0, up_max=0, sw_fault=0.
REQ-025 While rst=1, dn_max and the dn channel stable level SHALL be 1 (door assumed closed); dn synchronizer flops SHALL reset to 1.
REQ-026 Reset asserted mid-count or mid-pulse SHALL abort the count/pulse; after release, outputs change only via REQ-015..REQ-022.

Verification (DB_CYCLES=4)
REQ-027 Assert rst during an active btn count -> activate=0, up_max=0, dn_max=1, sw_fault=0 before next clk edge; no pulse after release.
REQ-028 btn_raw 0->1 held 20 cycles, then 0 -> single activate pulse at edge 6 after change; no pulse on release.
REQ-029 btn_raw high 3 cycles then low -> activate stays 0; counter returns to 0.
REQ-030 btn_raw toggles every cycle for 10 cycles then stays 1 -> exactly one activate pulse, 6 edges after the final 0->1.
REQ-031 dn_sw_raw 1->0 and up_sw_raw 0->1 same cycle -> dn_max falls and up_max rises on edge 6; sw_fault stays 0.
REQ-032 up_sw_raw and dn_sw_raw both 1 -> up_max=1 at edge 6 (dn_max already 1), sw_fault=1 at edge 7; btn press then -> no activate; drop up_sw_raw, wait for up_max=0, pulse fault_clr -> sw_fault=0 next edge; new press -> one activate pulse.
